intra_dc_pred_ctrl: RTL and testbench
=====================================

Name: intra_dc_pred_ctrl

Overview:
Sequencing controller for DC intra prediction of one square block. On a start pulse it reads the left-neighbour column and the top-neighbour row from two synchronous-read line buffers. It skips any neighbour side that is unavailable, accumulates the samples and produces the DC predictor value with a one-cycle valid pulse. It sits between the block-level scheduler (start, X/Y, availability) and the neighbour line buffers, and replaces free-running address generation with a handshaked, availability-aware sequence.

Parameters:
BIT_DEPTH, 8, sample width in bits.
BLK_LOG2, 2, log2 of block size N (legal 2..3; N = 4 or 8).

Ports:
CLK_HIGH  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
START  in  1  request pulse; accepted only when BUSY=0.
X  in  6  block column origin in neighbour-buffer units.
Y  in  6  block row origin in neighbour-buffer units.
AVAIL_LEFT  in  1  left neighbours valid.
AVAIL_TOP  in  1  top neighbours valid.
LEFT_RD_EN  out  1  left buffer read strobe.
LEFT_ADDR  out  8  left buffer address.
LEFT_DATA  in  BIT_DEPTH  left buffer read data; valid the cycle after LEFT_RD_EN.
TOP_RD_EN  out  1  top buffer read strobe.
TOP_ADDR  out  8  top buffer address.
TOP_DATA  in  BIT_DEPTH  top buffer read data; valid the cycle after TOP_RD_EN.
BUSY  out  1  high from the cycle after accept through the DRAIN cycle.
DC_VAL  out  BIT_DEPTH  DC predictor; holds its value until the next DC_VALID.
DC_VALID  out  1  one-cycle pulse, DC_VAL valid.

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; accumulators, counters and latched X/Y/avail cleared. Asserting RST mid-sequence aborts it; no DC_VALID follows.
- Accept: START=1 with BUSY=0 at a rising edge (edge 0). X, Y, AVAIL_LEFT and AVAIL_TOP are latched. Sum is cleared.
- START while BUSY=1 is ignored and not queued.
- START in the DC_VALID cycle is accepted, because BUSY=0 in that cycle.
- States: IDLE, RD_LEFT, RD_TOP, DRAIN, OUT.
- IDLE -> RD_LEFT if AVAIL_LEFT; else -> RD_TOP if AVAIL_TOP; else -> DRAIN.
- RD_LEFT: N cycles. LEFT_RD_EN=1, LEFT_ADDR = {2'b0,Y}+k for k=1..N. Then -> RD_TOP if AVAIL_TOP, else -> DRAIN.
- RD_TOP: N cycles. TOP_RD_EN=1, TOP_ADDR = {2'b0,X}+k for k=1..N. Then -> DRAIN.
- DRAIN: 1 cycle; captures the last returned sample. Then -> OUT.
- OUT: 1 cycle. DC_VALID=1, BUSY=0, DC_VAL updated. Then -> IDLE, or -> the next sequence if START is accepted in this cycle.
- Outside their read states, RD_EN strobes are 0 and addresses are 0.
- Data capture: a registered copy of each RD_EN qualifies the returned data one cycle later. Left and top samples go to separate accumulators, each BIT_DEPTH+BLK_LOG2 bits wide (no overflow).
- Address arithmetic: 8-bit unsigned. Maximum is 63+8=71, so no wrap occurs.
- DC computation, registered in OUT:
  - both available: (sumL+sumT+N) >> (BLK_LOG2+1)
  - left only: (sumL+N/2) >> BLK_LOG2
  - top only: (sumT+N/2) >> BLK_LOG2
  - neither: 1<<(BIT_DEPTH-1)
  - Results are truncated to BIT_DEPTH bits; they cannot exceed the maximum sample value.
- Latency (counted from edge 0, cycle 1 being the first after accept): reads occupy cycles 1..R, where R = N·(AVAIL_LEFT+AVAIL_TOP). DRAIN is cycle R+1. DC_VALID is high in cycle R+2.
  - N=4, both available: DC_VALID in cycle 10.
  - Neither available: DC_VALID in cycle 2.
- Left and top strobes are never asserted in the same cycle.

Test Plan:
- Address sequence, N=4: X=60, Y=5, both available -> LEFT_ADDR 6,7,8,9 in cycles 1-4; TOP_ADDR 61,62,63,64 in cycles 5-8; DC_VALID in cycle 10.
- Both available: left samples all 10, top samples all 20 -> sum=120, DC_VAL=(120+4)>>3=15.
- Left only: samples 1,2,3,4, AVAIL_TOP=0 -> no TOP_RD_EN; DC_VAL=(10+2)>>2=3 in cycle 6.
- Neither available -> no read strobes; DC_VAL=128, DC_VALID in cycle 2.
- Saturation, N=8: all samples 255, both available -> DC_VAL=255.
- START pulses in cycles 3 and 7 of a busy sequence -> ignored, single DC_VALID.
- Back-to-back START in the OUT cycle -> the second sequence begins reads the next cycle.
- RST pulsed in cycle 5 -> all outputs 0 immediately, no DC_VALID; a fresh START after reset completes normally.

Source files
------------

// File: rtl/intra_dc_pred_ctrl.sv
// DC intra prediction sequencer: walks the available left/top neighbour
// line buffers for one NxN block, accumulates the returned samples and
// emits the rounded DC predictor with a single-cycle valid pulse.
module intra_dc_pred_ctrl #(
  parameter int BIT_DEPTH = 8,
  parameter int BLK_LOG2  = 2
) (
  input  logic                 CLK_HIGH,
  input  logic                 RST,
  input  logic                 START,
  input  logic [5:0]           X,
  input  logic [5:0]           Y,
  input  logic                 AVAIL_LEFT,
  input  logic                 AVAIL_TOP,
  output logic                 LEFT_RD_EN,
  output logic [7:0]           LEFT_ADDR,
  input  logic [BIT_DEPTH-1:0] LEFT_DATA,
  output logic                 TOP_RD_EN,
  output logic [7:0]           TOP_ADDR,
  input  logic [BIT_DEPTH-1:0] TOP_DATA,
  output logic                 BUSY,
  output logic [BIT_DEPTH-1:0] DC_VAL,
  output logic                 DC_VALID
);

  localparam int N     = 1 << BLK_LOG2;
  localparam int ACC_W = BIT_DEPTH + BLK_LOG2;
  localparam int TOT_W = ACC_W + 2;

  typedef enum logic [2:0] {IDLE, RD_LEFT, RD_TOP, DRAIN, OUT} state_t;

  state_t               state, state_nxt;
  logic [BLK_LOG2-1:0]  cnt;
  logic                 cnt_last;
  logic                 accept;
  logic [5:0]           x_q, y_q;
  logic                 av_l_q, av_t_q;
  logic                 l_vld, t_vld;
  logic [ACC_W-1:0]     sum_l, sum_t, sum_l_nxt, sum_t_nxt;
  logic [TOT_W-1:0]     tot;
  logic [BIT_DEPTH-1:0] dc_nxt;

  // A new request is taken whenever the block is not busy, including OUT.
  assign accept   = START && ((state == IDLE) || (state == OUT));
  assign cnt_last = (cnt == BLK_LOG2'(N - 1));

  // State register.
  always_ff @(posedge CLK_HIGH or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: skip unavailable sides; OUT can chain straight into a new sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OUT: begin
        if (accept) begin
          if (AVAIL_LEFT)     state_nxt = RD_LEFT;
          else if (AVAIL_TOP) state_nxt = RD_TOP;
          else                state_nxt = DRAIN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_LEFT: if (cnt_last) state_nxt = av_t_q ? RD_TOP : DRAIN;
      RD_TOP:  if (cnt_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; addresses are forced to zero outside reads.
  always_comb begin
    LEFT_RD_EN = (state == RD_LEFT);
    TOP_RD_EN  = (state == RD_TOP);
    LEFT_ADDR  = '0;
    TOP_ADDR   = '0;
    if (LEFT_RD_EN) LEFT_ADDR = {2'b00, y_q} + 8'(cnt) + 8'd1;
    if (TOP_RD_EN)  TOP_ADDR  = {2'b00, x_q} + 8'(cnt) + 8'd1;
    BUSY       = (state == RD_LEFT) || (state == RD_TOP) || (state == DRAIN);
    DC_VALID   = (state == OUT);
  end

  // Sample index within the current side; restarts on every state change.
  always_ff @(posedge CLK_HIGH or posedge RST) begin
    if (RST)                                        cnt <= '0;
    else if (state_nxt != state)                    cnt <= '0;
    else if ((state == RD_LEFT) || (state == RD_TOP)) cnt <= cnt + 1'b1;
  end

  // Latch block origin and availability at accept time.
  always_ff @(posedge CLK_HIGH or posedge RST) begin
    if (RST) begin
      x_q    <= '0;
      y_q    <= '0;
      av_l_q <= 1'b0;
      av_t_q <= 1'b0;
    end else if (accept) begin
      x_q    <= X;
      y_q    <= Y;
      av_l_q <= AVAIL_LEFT;
      av_t_q <= AVAIL_TOP;
    end
  end

  // Delayed strobes mark the cycle in which buffer data is returned.
  always_ff @(posedge CLK_HIGH or posedge RST) begin
    if (RST) begin
      l_vld <= 1'b0;
      t_vld <= 1'b0;
    end else begin
      l_vld <= LEFT_RD_EN;
      t_vld <= TOP_RD_EN;
    end
  end

  assign sum_l_nxt = sum_l + (l_vld ? ACC_W'(LEFT_DATA) : '0);
  assign sum_t_nxt = sum_t + (t_vld ? ACC_W'(TOP_DATA)  : '0);

  // Separate left/top accumulators, cleared on accept.
  always_ff @(posedge CLK_HIGH or posedge RST) begin
    if (RST) begin
      sum_l <= '0;
      sum_t <= '0;
    end else if (accept) begin
      sum_l <= '0;
      sum_t <= '0;
    end else begin
      sum_l <= sum_l_nxt;
      sum_t <= sum_t_nxt;
    end
  end

  // Rounded average; uses the *_nxt sums so the sample arriving in DRAIN is included.
  always_comb begin
    tot    = '0;
    dc_nxt = {1'b1, {(BIT_DEPTH-1){1'b0}}};
    case ({av_l_q, av_t_q})
      2'b11: begin
        tot    = TOT_W'(sum_l_nxt) + TOT_W'(sum_t_nxt) + TOT_W'(N);
        dc_nxt = BIT_DEPTH'(tot >> (BLK_LOG2 + 1));
      end
      2'b10: begin
        tot    = TOT_W'(sum_l_nxt) + TOT_W'(N / 2);
        dc_nxt = BIT_DEPTH'(tot >> BLK_LOG2);
      end
      2'b01: begin
        tot    = TOT_W'(sum_t_nxt) + TOT_W'(N / 2);
        dc_nxt = BIT_DEPTH'(tot >> BLK_LOG2);
      end
      default: ;
    endcase
  end

  // DC result register, loaded on the DRAIN->OUT edge and held until the next one.
  always_ff @(posedge CLK_HIGH or posedge RST) begin
    if (RST)                 DC_VAL <= '0;
    else if (state == DRAIN) DC_VAL <= dc_nxt;
  end

endmodule

// File: tb/tb_intra_dc_pred_ctrl.sv
// Bench for intra_dc_pred_ctrl: N=4 and N=8 instances behind a shared
// synchronous-read neighbour memory model, with an expected-DC scoreboard.
module tb_intra_dc_pred_ctrl;

  logic CLK_HIGH = 1'b0;
  always #5 CLK_HIGH = ~CLK_HIGH;

  logic       RST, START4, START8, AVAIL_LEFT, AVAIL_TOP;
  logic [5:0] X, Y;

  logic       l_rd4, t_rd4, busy4, vld4, l_rd8, t_rd8, busy8, vld8;
  logic [7:0] la4, ta4, dc4, ld4, td4, la8, ta8, dc8, ld8, td8;

  logic [7:0] left_mem [256];
  logic [7:0] top_mem  [256];

  intra_dc_pred_ctrl #(.BIT_DEPTH(8), .BLK_LOG2(2)) u_dut4 (
    .CLK_HIGH(CLK_HIGH), .RST(RST), .START(START4), .X(X), .Y(Y),
    .AVAIL_LEFT(AVAIL_LEFT), .AVAIL_TOP(AVAIL_TOP),
    .LEFT_RD_EN(l_rd4), .LEFT_ADDR(la4), .LEFT_DATA(ld4),
    .TOP_RD_EN(t_rd4), .TOP_ADDR(ta4), .TOP_DATA(td4),
    .BUSY(busy4), .DC_VAL(dc4), .DC_VALID(vld4));

  intra_dc_pred_ctrl #(.BIT_DEPTH(8), .BLK_LOG2(3)) u_dut8 (
    .CLK_HIGH(CLK_HIGH), .RST(RST), .START(START8), .X(X), .Y(Y),
    .AVAIL_LEFT(AVAIL_LEFT), .AVAIL_TOP(AVAIL_TOP),
    .LEFT_RD_EN(l_rd8), .LEFT_ADDR(la8), .LEFT_DATA(ld8),
    .TOP_RD_EN(t_rd8), .TOP_ADDR(ta8), .TOP_DATA(td8),
    .BUSY(busy8), .DC_VAL(dc8), .DC_VALID(vld8));

  // Line buffer model: data one cycle after the read strobe.
  always @(posedge CLK_HIGH) begin
    if (l_rd4) ld4 <= left_mem[la4];
    if (t_rd4) td4 <= top_mem[ta4];
    if (l_rd8) ld8 <= left_mem[la8];
    if (t_rd8) td8 <= top_mem[ta8];
  end

  logic       sel8;
  logic       s_lrd, s_trd, s_busy, s_vld;
  logic [7:0] s_la, s_ta, s_dc;
  always_comb begin
    s_lrd  = sel8 ? l_rd8 : l_rd4;
    s_trd  = sel8 ? t_rd8 : t_rd4;
    s_busy = sel8 ? busy8 : busy4;
    s_vld  = sel8 ? vld8  : vld4;
    s_la   = sel8 ? la8   : la4;
    s_ta   = sel8 ? ta8   : ta4;
    s_dc   = sel8 ? dc8   : dc4;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  // Observations from the last run_seq.
  logic [7:0] obs_la [16];
  logic [7:0] obs_ta [16];
  int         obs_lc [16];
  int         obs_tc [16];
  int         obs_nl, obs_nt, obs_busy, obs_vcyc;
  logic       obs_ovl, obs_busy_v;
  logic [7:0] obs_dc, obs_exp;

  function automatic logic [7:0] exp_dc(input logic al, input logic at,
                                        input logic [5:0] x, input logic [5:0] y,
                                        input int lg2);
    int n;
    int sl;
    int st;
    n = 1 << lg2;
    sl = 0;
    st = 0;
    for (int k = 1; k <= n; k++) begin
      sl += int'(left_mem[int'(y) + k]);
      st += int'(top_mem[int'(x) + k]);
    end
    if (al && at) return 8'((sl + st + n) >> (lg2 + 1));
    if (al)       return 8'((sl + n / 2) >> lg2);
    if (at)       return 8'((st + n / 2) >> lg2);
    return 8'd128;
  endfunction

  // Drive one request (cycle 0), then record strobes per cycle until DC_VALID or 40 cycles.
  task automatic run_seq(input logic s8, input logic [5:0] x, input logic [5:0] y,
                         input logic al, input logic at);
    sel8 = s8;
    obs_nl = 0; obs_nt = 0; obs_busy = 0; obs_vcyc = -1;
    obs_ovl = 1'b0; obs_busy_v = 1'bx; obs_dc = 8'h00; obs_exp = 8'hxx;
    @(negedge CLK_HIGH);
    X = x; Y = y; AVAIL_LEFT = al; AVAIL_TOP = at;
    if (s8) START8 = 1'b1; else START4 = 1'b1;
    exp_q.push_back(exp_dc(al, at, x, y, s8 ? 3 : 2));
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK_HIGH);
      START4 = 1'b0;
      START8 = 1'b0;
      if (s_lrd && obs_nl < 16) begin obs_la[obs_nl] = s_la; obs_lc[obs_nl] = c; obs_nl++; end
      if (s_trd && obs_nt < 16) begin obs_ta[obs_nt] = s_ta; obs_tc[obs_nt] = c; obs_nt++; end
      if (s_lrd && s_trd) obs_ovl = 1'b1;
      if (s_busy) obs_busy++;
      if (s_vld) begin
        obs_vcyc = c; obs_dc = s_dc; obs_busy_v = s_busy;
        if (exp_q.size() > 0) obs_exp = exp_q.pop_front();
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; START4 = 1'b0; START8 = 1'b0;
    X = '0; Y = '0; AVAIL_LEFT = 1'b0; AVAIL_TOP = 1'b0; sel8 = 1'b0;
    repeat (2) @(negedge CLK_HIGH);
    checks++;
    if ({l_rd4, la4, t_rd4, ta4, busy4, dc4, vld4} !== 35'd0) begin
      errors++; $display("FAIL reset_n4 got %h want 0", {l_rd4, la4, t_rd4, ta4, busy4, dc4, vld4});
    end
    checks++;
    if ({l_rd8, la8, t_rd8, ta8, busy8, dc8, vld8} !== 35'd0) begin
      errors++; $display("FAIL reset_n8 got %h want 0", {l_rd8, la8, t_rd8, ta8, busy8, dc8, vld8});
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK_HIGH);
    checks++;
    if ({l_rd4, t_rd4, busy4, vld4, dc4} !== 12'd0) begin
      errors++; $display("FAIL idle_after_reset got %h want 0", {l_rd4, t_rd4, busy4, vld4, dc4});
    end
  endtask

  task automatic test_addr_seq;
    for (int k = 6; k <= 9; k++) left_mem[k] = 8'd10;
    for (int k = 61; k <= 64; k++) top_mem[k] = 8'd20;
    run_seq(1'b0, 6'd60, 6'd5, 1'b1, 1'b1);
    checks++;
    if (obs_nl !== 4 || obs_nt !== 4) begin
      errors++; $display("FAIL addr_counts got %0d/%0d want 4/4", obs_nl, obs_nt);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_la[k] !== 8'(6 + k) || obs_lc[k] !== k + 1) begin
        errors++; $display("FAIL left_addr[%0d] got %0d@%0d want %0d@%0d", k, obs_la[k], obs_lc[k], 6 + k, k + 1);
      end
      checks++;
      if (obs_ta[k] !== 8'(61 + k) || obs_tc[k] !== k + 5) begin
        errors++; $display("FAIL top_addr[%0d] got %0d@%0d want %0d@%0d", k, obs_ta[k], obs_tc[k], 61 + k, k + 5);
      end
    end
    checks++;
    if (obs_vcyc !== 10) begin errors++; $display("FAIL both_latency got %0d want 10", obs_vcyc); end
    checks++;
    if (obs_dc !== 8'd15 || obs_dc !== obs_exp) begin
      errors++; $display("FAIL both_dc got %0d want %0d", obs_dc, obs_exp);
    end
    checks++;
    if (obs_busy !== 9 || obs_busy_v !== 1'b0) begin
      errors++; $display("FAIL busy_window got %0d/%b want 9/0", obs_busy, obs_busy_v);
    end
    checks++;
    if (obs_ovl !== 1'b0) begin errors++; $display("FAIL strobe_overlap got 1 want 0"); end
  endtask

  task automatic test_left_only;
    for (int k = 1; k <= 4; k++) left_mem[20 + k] = 8'(k);
    run_seq(1'b0, 6'd3, 6'd20, 1'b1, 1'b0);
    checks++;
    if (obs_nt !== 0 || obs_nl !== 4) begin
      errors++; $display("FAIL left_only_strobes got %0d/%0d want 4/0", obs_nl, obs_nt);
    end
    checks++;
    if (obs_vcyc !== 6) begin errors++; $display("FAIL left_only_latency got %0d want 6", obs_vcyc); end
    checks++;
    if (obs_dc !== 8'd3 || obs_dc !== obs_exp) begin
      errors++; $display("FAIL left_only_dc got %0d want %0d", obs_dc, obs_exp);
    end
  endtask

  task automatic test_top_only;
    for (int k = 41; k <= 44; k++) top_mem[k] = 8'($urandom_range(0, 255));
    run_seq(1'b0, 6'd40, 6'd0, 1'b0, 1'b1);
    checks++;
    if (obs_nl !== 0 || obs_nt !== 4 || obs_ta[0] !== 8'd41) begin
      errors++; $display("FAIL top_only_strobes got %0d/%0d first %0d want 0/4 first 41", obs_nl, obs_nt, obs_ta[0]);
    end
    checks++;
    if (obs_vcyc !== 6 || obs_dc !== obs_exp) begin
      errors++; $display("FAIL top_only got dc %0d@%0d want %0d@6", obs_dc, obs_vcyc, obs_exp);
    end
  endtask

  task automatic test_none;
    run_seq(1'b0, 6'd7, 6'd9, 1'b0, 1'b0);
    checks++;
    if (obs_nl !== 0 || obs_nt !== 0) begin
      errors++; $display("FAIL none_strobes got %0d/%0d want 0/0", obs_nl, obs_nt);
    end
    checks++;
    if (obs_vcyc !== 2 || obs_dc !== 8'd128) begin
      errors++; $display("FAIL none got dc %0d@%0d want 128@2", obs_dc, obs_vcyc);
    end
  endtask

  task automatic test_saturation;
    for (int k = 64; k <= 71; k++) begin left_mem[k] = 8'd255; top_mem[k] = 8'd255; end
    run_seq(1'b1, 6'd63, 6'd63, 1'b1, 1'b1);
    checks++;
    if (obs_nl !== 8 || obs_nt !== 8 || obs_la[7] !== 8'd71 || obs_ta[7] !== 8'd71) begin
      errors++; $display("FAIL sat_addr got %0d/%0d last %0d/%0d want 8/8 last 71/71", obs_nl, obs_nt, obs_la[7], obs_ta[7]);
    end
    checks++;
    if (obs_vcyc !== 18 || obs_dc !== 8'd255) begin
      errors++; $display("FAIL sat_dc got %0d@%0d want 255@18", obs_dc, obs_vcyc);
    end
  endtask

  task automatic test_random;
    logic s8, al, at;
    logic [5:0] x, y;
    int exp_cyc;
    for (int k = 0; k < 256; k++) begin
      left_mem[k] = 8'($urandom_range(0, 255));
      top_mem[k]  = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 10; i++) begin
      s8 = 1'($urandom_range(0, 1)); al = 1'($urandom_range(0, 1)); at = 1'($urandom_range(0, 1));
      x  = 6'($urandom_range(0, 63)); y = 6'($urandom_range(0, 63));
      exp_cyc = (s8 ? 8 : 4) * (int'(al) + int'(at)) + 2;
      run_seq(s8, x, y, al, at);
      checks++;
      if (obs_vcyc !== exp_cyc || obs_dc !== obs_exp || obs_ovl !== 1'b0) begin
        errors++; $display("FAIL random[%0d] got dc %0d@%0d ovl %b want %0d@%0d", i, obs_dc, obs_vcyc, obs_ovl, obs_exp, exp_cyc);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int nv, vc, first_top;
    logic [7:0] got, exp;
    nv = 0; vc = -1; first_top = -1; got = 8'h00; exp = 8'hxx;
    sel8 = 1'b0;
    @(negedge CLK_HIGH);
    X = 6'd12; Y = 6'd30; AVAIL_LEFT = 1'b1; AVAIL_TOP = 1'b1; START4 = 1'b1;
    exp_q.push_back(exp_dc(1'b1, 1'b1, 6'd12, 6'd30, 2));
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK_HIGH);
      if (vld4) begin
        nv++; vc = c; got = dc4;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
      end
      if (t_rd4 && first_top < 0) first_top = int'(ta4);
      START4 = (c == 3) || (c == 7);
      if (c == 3) begin X = 6'd0; AVAIL_TOP = 1'b0; end
    end
    START4 = 1'b0;
    checks++;
    if (nv !== 1 || vc !== 10) begin
      errors++; $display("FAIL busy_ignore got %0d valids last@%0d want 1@10", nv, vc);
    end
    checks++;
    if (first_top !== 13 || got !== exp) begin
      errors++; $display("FAIL busy_ignore_data got top %0d dc %0d want 13 dc %0d", first_top, got, exp);
    end
  endtask

  task automatic test_back_to_back;
    int nv, v1, v2;
    logic rd11;
    logic [7:0] a11, g1, g2, e1, e2;
    nv = 0; v1 = -1; v2 = -1; rd11 = 1'b0; a11 = 8'h00;
    g1 = 8'h00; g2 = 8'h00; e1 = 8'hxx; e2 = 8'hxx;
    sel8 = 1'b0;
    @(negedge CLK_HIGH);
    X = 6'd8; Y = 6'd16; AVAIL_LEFT = 1'b1; AVAIL_TOP = 1'b1; START4 = 1'b1;
    exp_q.push_back(exp_dc(1'b1, 1'b1, 6'd8, 6'd16, 2));
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK_HIGH);
      START4 = 1'b0;
      if (c == 11) begin rd11 = l_rd4; a11 = la4; end
      if (vld4) begin
        nv++;
        if (nv == 1) begin
          v1 = c; g1 = dc4;
          if (exp_q.size() > 0) e1 = exp_q.pop_front();
          // Second request issued during the OUT cycle.
          X = 6'd1; Y = 6'd30; AVAIL_LEFT = 1'b1; AVAIL_TOP = 1'b0; START4 = 1'b1;
          exp_q.push_back(exp_dc(1'b1, 1'b0, 6'd1, 6'd30, 2));
        end else begin
          v2 = c; g2 = dc4;
          if (exp_q.size() > 0) e2 = exp_q.pop_front();
        end
      end
    end
    checks++;
    if (v1 !== 10 || g1 !== e1) begin
      errors++; $display("FAIL b2b_first got %0d@%0d want %0d@10", g1, v1, e1);
    end
    checks++;
    if (rd11 !== 1'b1 || a11 !== 8'd31) begin
      errors++; $display("FAIL b2b_restart got rd %b addr %0d want rd 1 addr 31", rd11, a11);
    end
    checks++;
    if (nv !== 2 || v2 !== 16 || g2 !== e2) begin
      errors++; $display("FAIL b2b_second got n %0d dc %0d@%0d want n 2 dc %0d@16", nv, g2, v2, e2);
    end
  endtask

  task automatic test_reset_mid;
    int nv;
    nv = 0;
    sel8 = 1'b0;
    @(negedge CLK_HIGH);
    X = 6'd2; Y = 6'd2; AVAIL_LEFT = 1'b1; AVAIL_TOP = 1'b1; START4 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK_HIGH);
      START4 = 1'b0;
      if (vld4) nv++;
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({l_rd4, la4, t_rd4, ta4, busy4, dc4, vld4} !== 35'd0) begin
      errors++; $display("FAIL reset_mid_outputs got %h want 0", {l_rd4, la4, t_rd4, ta4, busy4, dc4, vld4});
    end
    @(negedge CLK_HIGH);
    RST = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK_HIGH);
      if (vld4 || busy4) nv++;
    end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL reset_mid_abort got %0d valid/busy cycles want 0", nv); end
    run_seq(1'b0, 6'd33, 6'd44, 1'b1, 1'b1);
    checks++;
    if (obs_vcyc !== 10 || obs_dc !== obs_exp) begin
      errors++; $display("FAIL reset_mid_recover got %0d@%0d want %0d@10", obs_dc, obs_vcyc, obs_exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin left_mem[k] = 8'd0; top_mem[k] = 8'd0; end
    test_reset();
    test_addr_seq();
    test_left_only();
    test_top_only();
    test_none();
    test_saturation();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
